// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: EX-to-WB memory stage with request/response data bus
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ex_valid,
    input  logic [3:0]        i_mem_op,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [ADDR_W-1:0] i_store_data,
    input  logic              i_ex_wreg,
    input  logic [4:0]        i_ex_waddr,
    input  logic [ADDR_W-1:0] i_ex_wdata,
    input  logic              i_flush,
    output logic              o_data_req,
    output logic              o_data_we,
    output logic [3:0]        o_data_wstrb,
    output logic [ADDR_W-1:0] o_data_addr,
    output logic [ADDR_W-1:0] o_data_wdata,
    input  logic              i_data_addr_ok,
    input  logic              i_data_data_ok,
    input  logic [ADDR_W-1:0] i_data_rdata,
    output logic              o_wb_valid,
    output logic              o_wb_wreg,
    output logic [4:0]        o_wb_waddr,
    output logic [ADDR_W-1:0] o_wb_wdata,
    output logic              o_excp_ale,
    output logic [ADDR_W-1:0] o_excp_badv,
    output logic              o_stallreq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [3:0] OP_LD_B  = 4'd1;
    localparam logic [3:0] OP_LD_H  = 4'd2;
    localparam logic [3:0] OP_LD_W  = 4'd3;
    localparam logic [3:0] OP_LD_BU = 4'd4;
    localparam logic [3:0] OP_LD_HU = 4'd5;
    localparam logic [3:0] OP_ST_B  = 4'd6;
    localparam logic [3:0] OP_ST_H  = 4'd7;
    localparam logic [3:0] OP_ST_W  = 4'd8;

    state_t r_state;
    state_t w_next_state;

    // latched memory instruction, owned by the FSM between IDLE and completion
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_sdata;
    logic [4:0]        r_waddr;
    logic              r_wreg;

    logic              r_wb_valid;
    logic              r_wb_wreg;
    logic [4:0]        r_wb_waddr;
    logic [ADDR_W-1:0] r_wb_wdata;
    logic              r_excp_ale;
    logic [ADDR_W-1:0] r_excp_badv;

    logic w_in_mem;
    logic w_in_half;
    logic w_in_word;
    logic w_in_misalign;
    logic w_accept;
    logic w_ale;
    logic w_pass;
    logic w_done;

    logic              w_r_load;
    logic              w_r_store;
    logic [7:0]        w_lbyte;
    logic [15:0]       w_lhalf;
    logic [ADDR_W-1:0] w_ld_data;

    // decode of the incoming EX operation; opcodes 9-15 fall through as non-memory
    always_comb begin
        w_in_mem      = (i_mem_op >= OP_LD_B) && (i_mem_op <= OP_ST_W);
        w_in_half     = (i_mem_op == OP_LD_H) || (i_mem_op == OP_LD_HU) || (i_mem_op == OP_ST_H);
        w_in_word     = (i_mem_op == OP_LD_W) || (i_mem_op == OP_ST_W);
        w_in_misalign = (w_in_half && i_mem_addr[0]) || (w_in_word && (i_mem_addr[1:0] != 2'b00));
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state and per-cycle event strobes; a flush coinciding with data_ok kills the writeback
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ale        = 1'b0;
        w_pass       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ex_valid && !i_flush) begin
                    if (!w_in_mem) begin
                        w_pass = 1'b1;
                    end else if (w_in_misalign) begin
                        w_ale = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = REQ;
                    end
                end
            end
            REQ: begin
                if (i_data_addr_ok) begin
                    if (i_data_data_ok) begin
                        w_next_state = IDLE;
                        w_done       = !i_flush;
                    end else begin
                        w_next_state = i_flush ? DISCARD : WAIT;
                    end
                end else if (i_flush) begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                if (i_data_data_ok) begin
                    w_next_state = IDLE;
                    w_done       = !i_flush;
                end else if (i_flush) begin
                    w_next_state = DISCARD;
                end
            end
            DISCARD: begin
                if (i_data_data_ok) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // latch the accepted memory instruction; held stable until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= 4'd0;
            r_addr  <= '0;
            r_sdata <= '0;
            r_waddr <= 5'd0;
            r_wreg  <= 1'b0;
        end else if (w_accept) begin
            r_op    <= i_mem_op;
            r_addr  <= i_mem_addr;
            r_sdata <= i_store_data;
            r_waddr <= i_ex_waddr;
            r_wreg  <= i_ex_wreg;
        end
    end

    // bus request channel, driven only while in REQ
    always_comb begin
        w_r_load     = (r_op >= OP_LD_B) && (r_op <= OP_LD_HU);
        w_r_store    = (r_op >= OP_ST_B) && (r_op <= OP_ST_W);
        o_data_req   = 1'b0;
        o_data_we    = 1'b0;
        o_data_wstrb = 4'b0000;
        o_data_addr  = '0;
        o_data_wdata = '0;
        if (r_state == REQ) begin
            o_data_req  = 1'b1;
            o_data_we   = w_r_store;
            o_data_addr = {r_addr[ADDR_W-1:2], 2'b00};
            case (r_op)
                OP_ST_B: begin
                    o_data_wstrb = 4'b0001 << r_addr[1:0];
                    o_data_wdata = {4{r_sdata[7:0]}};
                end
                OP_ST_H: begin
                    o_data_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                    o_data_wdata = {2{r_sdata[15:0]}};
                end
                OP_ST_W: begin
                    o_data_wstrb = 4'b1111;
                    o_data_wdata = r_sdata;
                end
                default: begin
                    o_data_wstrb = 4'b0000;
                    o_data_wdata = '0;
                end
            endcase
        end
    end

    // lane selection and extension of the read response
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_lbyte = i_data_rdata[7:0];
            2'd1:    w_lbyte = i_data_rdata[15:8];
            2'd2:    w_lbyte = i_data_rdata[23:16];
            default: w_lbyte = i_data_rdata[31:24];
        endcase
        w_lhalf = r_addr[1] ? i_data_rdata[31:16] : i_data_rdata[15:0];
        case (r_op)
            OP_LD_B:  w_ld_data = {{24{w_lbyte[7]}}, w_lbyte};
            OP_LD_H:  w_ld_data = {{16{w_lhalf[15]}}, w_lhalf};
            OP_LD_W:  w_ld_data = i_data_rdata;
            OP_LD_BU: w_ld_data = {24'd0, w_lbyte};
            OP_LD_HU: w_ld_data = {16'd0, w_lhalf};
            default:  w_ld_data = '0;
        endcase
    end

    // write-back register: one-cycle valid pulse, payload holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_wb_wreg   <= 1'b0;
            r_wb_waddr  <= 5'd0;
            r_wb_wdata  <= '0;
            r_excp_ale  <= 1'b0;
            r_excp_badv <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_pass) begin
                r_wb_valid <= 1'b1;
                r_wb_wreg  <= i_ex_wreg;
                r_wb_waddr <= i_ex_waddr;
                r_wb_wdata <= i_ex_wdata;
                r_excp_ale <= 1'b0;
            end else if (w_ale) begin
                r_wb_valid  <= 1'b1;
                r_wb_wreg   <= 1'b0;
                r_wb_waddr  <= i_ex_waddr;
                r_wb_wdata  <= '0;
                r_excp_ale  <= 1'b1;
                r_excp_badv <= i_mem_addr;
            end else if (w_done) begin
                r_wb_valid <= 1'b1;
                r_wb_wreg  <= r_wreg && w_r_load;
                r_wb_waddr <= r_waddr;
                r_wb_wdata <= w_r_load ? w_ld_data : '0;
                r_excp_ale <= 1'b0;
            end
        end
    end

    // stall is gated by reset so it drops immediately on an asynchronous reset
    always_comb begin
        o_stallreq  = !rst && ((r_state != IDLE) || w_accept);
        o_wb_valid  = r_wb_valid;
        o_wb_wreg   = r_wb_wreg;
        o_wb_waddr  = r_wb_waddr;
        o_wb_wdata  = r_wb_wdata;
        o_excp_ale  = r_excp_ale;
        o_excp_badv = r_excp_badv;
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        flush;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        wb_valid;
    logic        wb_wreg;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        excp_ale;
    logic [31:0] excp_badv;
    logic        stallreq;

    int n_chk  = 0;
    int n_fail = 0;

    lsu #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ex_valid     (ex_valid),
        .i_mem_op       (mem_op),
        .i_mem_addr     (mem_addr),
        .i_store_data   (store_data),
        .i_ex_wreg      (ex_wreg),
        .i_ex_waddr     (ex_waddr),
        .i_ex_wdata     (ex_wdata),
        .i_flush        (flush),
        .o_data_req     (data_req),
        .o_data_we      (data_we),
        .o_data_wstrb   (data_wstrb),
        .o_data_addr    (data_addr),
        .o_data_wdata   (data_wdata),
        .i_data_addr_ok (addr_ok),
        .i_data_data_ok (data_ok),
        .i_data_rdata   (rdata),
        .o_wb_valid     (wb_valid),
        .o_wb_wreg      (wb_wreg),
        .o_wb_waddr     (wb_waddr),
        .o_wb_wdata     (wb_wdata),
        .o_excp_ale     (excp_ale),
        .o_excp_badv    (excp_badv),
        .o_stallreq     (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic wreg, input logic [4:0] waddr, input logic [31:0] wdata);
        ex_valid   = 1'b1;
        mem_op     = op;
        mem_addr   = addr;
        store_data = sd;
        ex_wreg    = wreg;
        ex_waddr   = waddr;
        ex_wdata   = wdata;
    endtask

    task automatic idle_bus();
        ex_valid = 1'b0;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; mem_op = 4'd0; mem_addr = 32'd0; store_data = 32'd0;
        ex_wreg = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; flush = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;

        // reset state
        @(negedge clk);
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_excp_ale", {31'd0, excp_ale}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // non-memory pass-through
        issue(4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
        #1 chk("pass_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        chk("pass_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("pass_wb_wdata", wb_wdata, 32'h1234);
        chk("pass_wb_waddr", {27'd0, wb_waddr}, 32'd5);
        chk("pass_wb_wreg", {31'd0, wb_wreg}, 32'd1);
        chk("pass_no_req", {31'd0, data_req}, 32'd0);
        idle_bus();
        @(negedge clk);
        chk("pass_pulse", {31'd0, wb_valid}, 32'd0);
        chk("pass_hold", wb_wdata, 32'h1234);

        // LD.B with addr_ok and data_ok together
        issue(4'd1, 32'h1003, 32'h0, 1'b1, 5'd7, 32'h0);
        #1 chk("ldb_accept_stall", {31'd0, stallreq}, 32'd1);
        @(negedge clk);
        chk("ldb_req", {31'd0, data_req}, 32'd1);
        chk("ldb_addr", data_addr, 32'h1000);
        chk("ldb_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("ldb_we", {31'd0, data_we}, 32'd0);
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("ldb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ldb_wb_wdata", wb_wdata, 32'hFFFF_FF80);
        chk("ldb_wb_waddr", {27'd0, wb_waddr}, 32'd7);
        chk("ldb_wb_wreg", {31'd0, wb_wreg}, 32'd1);
        idle_bus();
        #1 chk("ldb_idle_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);

        // LD.BU through WAIT
        issue(4'd4, 32'h1003, 32'h0, 1'b1, 5'd8, 32'h0);
        @(negedge clk);
        addr_ok = 1'b1;
        @(negedge clk);
        chk("ldbu_wait_req", {31'd0, data_req}, 32'd0);
        chk("ldbu_wait_stall", {31'd0, stallreq}, 32'd1);
        chk("ldbu_wait_wbv", {31'd0, wb_valid}, 32'd0);
        addr_ok = 1'b0; data_ok = 1'b1;
        @(negedge clk);
        chk("ldbu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ldbu_wb_wdata", wb_wdata, 32'h0000_0080);
        idle_bus();
        @(negedge clk);

        // ST.H upper half
        issue(4'd7, 32'h2002, 32'h0000_ABCD, 1'b1, 5'd9, 32'h0);
        @(negedge clk);
        chk("sth_addr", data_addr, 32'h2000);
        chk("sth_wstrb", {28'd0, data_wstrb}, 32'hC);
        chk("sth_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sth_we", {31'd0, data_we}, 32'd1);
        addr_ok = 1'b1; data_ok = 1'b1;
        @(negedge clk);
        chk("sth_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sth_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        idle_bus();
        @(negedge clk);

        // misaligned LD.W
        issue(4'd3, 32'h3001, 32'h0, 1'b1, 5'd4, 32'h0);
        #1 chk("ale_no_stall", {31'd0, stallreq}, 32'd0);
        chk("ale_no_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        chk("ale_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ale_flag", {31'd0, excp_ale}, 32'd1);
        chk("ale_badv", excp_badv, 32'h3001);
        chk("ale_wreg", {31'd0, wb_wreg}, 32'd0);
        chk("ale_no_req2", {31'd0, data_req}, 32'd0);
        idle_bus();
        @(negedge clk);
        chk("ale_pulse", {31'd0, wb_valid}, 32'd0);

        // LD.W, slow addr_ok, flush in WAIT, late data_ok
        issue(4'd3, 32'h4000, 32'h0, 1'b1, 5'd2, 32'h0);
        @(negedge clk);
        chk("dis_req1", {31'd0, data_req}, 32'd1);
        @(negedge clk);
        chk("dis_req2", {31'd0, data_req}, 32'd1);
        chk("dis_stall2", {31'd0, stallreq}, 32'd1);
        @(negedge clk);
        addr_ok = 1'b1;
        @(negedge clk);
        chk("dis_wait_req", {31'd0, data_req}, 32'd0);
        chk("dis_wait_stall", {31'd0, stallreq}, 32'd1);
        addr_ok = 1'b0; flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("dis_stall_a", {31'd0, stallreq}, 32'd1);
        chk("dis_wbv_a", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        chk("dis_stall_b", {31'd0, stallreq}, 32'd1);
        chk("dis_wbv_b", {31'd0, wb_valid}, 32'd0);
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_ok = 1'b0;
        chk("dis_end_wbv", {31'd0, wb_valid}, 32'd0);
        chk("dis_end_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        chk("dis_after_wbv", {31'd0, wb_valid}, 32'd0);

        // flush in REQ before addr_ok
        issue(4'd3, 32'h5000, 32'h0, 1'b1, 5'd3, 32'h0);
        @(negedge clk);
        chk("frq_req", {31'd0, data_req}, 32'd1);
        flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("frq_req_drop", {31'd0, data_req}, 32'd0);
        chk("frq_stall", {31'd0, stallreq}, 32'd0);
        chk("frq_wbv", {31'd0, wb_valid}, 32'd0);

        // flush in IDLE
        issue(4'd0, 32'h0, 32'h0, 1'b1, 5'd6, 32'h5555);
        flush = 1'b1;
        @(negedge clk);
        chk("fid_wbv", {31'd0, wb_valid}, 32'd0);
        idle_bus();
        @(negedge clk);

        // asynchronous reset during REQ
        issue(4'd3, 32'h6000, 32'h0, 1'b1, 5'd1, 32'h0);
        @(negedge clk);
        chk("arst_pre_req", {31'd0, data_req}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("arst_req", {31'd0, data_req}, 32'd0);
        chk("arst_stall", {31'd0, stallreq}, 32'd0);
        chk("arst_addr", data_addr, 32'd0);
        chk("arst_ale", {31'd0, excp_ale}, 32'd0);
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0; data_ok = 1'b1;
        @(negedge clk);
        data_ok = 1'b0;
        chk("arst_late_ok_wbv", {31'd0, wb_valid}, 32'd0);
        chk("arst_late_ok_req", {31'd0, data_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W, default 32, address and data width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  EX result valid this cycle.
REQ-005 mem_op  input  4  memory operation code:
- 0 = none
- 1 = LD.B, 2 = LD.H, 3 = LD.W, 4 = LD.BU, 5 = LD.HU
- 6 = ST.B, 7 = ST.H, 8 = ST.W
- 9-15 = treated as none
REQ-006 mem_addr  input  32  effective address from EX.
REQ-007 store_data  input  32  store operand (EX reg2).
REQ-008 ex_wreg / ex_waddr / ex_wdata  input  1/5/32  EX register-write info.
REQ-009 flush  input  1  kill in-flight and incoming instruction.
REQ-010 data_req / data_we / data_wstrb / data_addr / data_wdata  output  1/1/4/32/32  data-bus request channel.
REQ-011 data_addr_ok / data_data_ok / data_rdata  input  1/1/32  request accepted / response valid / read data.
REQ-012 wb_valid / wb_wreg / wb_waddr / wb_wdata  output  1/1/5/32  registered result to write-back.
REQ-013 excp_ale / excp_badv  output  1/32  misaligned-access exception and faulting address, qualified by wb_valid.
REQ-014 stallreq  output  1  asks upstream to hold EX.

Function
REQ-015 FSM states are IDLE, REQ, WAIT, DISCARD; the reset state is IDLE.
REQ-016 In IDLE with ex_valid, !flush, and mem_op none: wb_* SHALL be registered from ex_* with 1-cycle latency and wb_valid=1.
REQ-017 Alignment: H ops need addr[0]=0; W ops need addr[1:0]=0. On violation the LSU SHALL issue no bus request.
- Next cycle: wb_valid=1, excp_ale=1, excp_badv=mem_addr, wb_wreg=0.
REQ-018 In IDLE, an aligned memory op without flush SHALL latch op, addr, waddr and wreg, then go to REQ.
REQ-019 In REQ: data_req=1, data_addr = latched addr with [1:0] forced to 0, and data_we=1 for stores.
- data_wstrb: B = 0001 shifted left by addr[1:0]; H = 0011 shifted left by addr[1]*2; W = 1111; loads drive 0000.
- data_wdata: byte replicated x4 for B, half replicated x2 for H, full word for W.
REQ-020 REQ transitions:
- addr_ok=1 -> WAIT.
- addr_ok=1 and data_ok=1 in the same cycle -> complete directly per REQ-021.
REQ-021 WAIT leaves on data_ok -> IDLE, with wb_valid=1 the next cycle.
- Loads: wb_wdata = byte/half selected by addr[1:0], sign-extended (B, H) or zero-extended (BU, HU).
- Stores: wb_wreg=0.
REQ-022 stallreq SHALL be 1 in REQ, WAIT and DISCARD, and 1 in IDLE while an aligned memory op is being accepted; otherwise 0.
REQ-023 While stallreq=1, EX inputs are held and SHALL NOT be re-accepted until the LSU returns to IDLE.
REQ-024 Flush in IDLE: the incoming instruction is dropped and wb_valid=0 next cycle.
REQ-025 Flush in REQ before addr_ok: data_req drops next cycle and the FSM returns to IDLE.
REQ-026 Flush in REQ with addr_ok: go to DISCARD, or to IDLE if data_ok is also 1.
REQ-027 Flush in WAIT: go to DISCARD.
REQ-028 DISCARD waits for data_ok, then returns to IDLE with wb_valid=0; the response is never written back.
REQ-029 wb_valid SHALL be a single-cycle pulse per completed instruction; wb_* SHALL hold their last values when wb_valid=0.

Reset
REQ-030 rst=1 SHALL asynchronously force state=IDLE and zero every output: data_req, data_we, data_wstrb, data_addr, data_wdata, wb_*, excp_*, stallreq.
REQ-031 A reset mid-transaction SHALL abandon the transaction; any later data_ok while in IDLE SHALL be ignored.

Verification
REQ-032 Non-memory op, ex_wdata=0x1234 -> wb_valid=1 and wb_wdata=0x1234 one cycle later; data_req never asserted.
REQ-033 LD.B addr=0x1003, rdata=0x80FF_0000 -> data_addr=0x1000, wstrb=0000, wb_wdata=0xFFFFFF80.
- Repeat with LD.BU -> wb_wdata=0x00000080.
REQ-034 ST.H addr=0x2002, store_data=0xABCD -> wstrb=1100, wdata=0xABCDABCD, data_we=1, wb_wreg=0.
REQ-035 LD.W addr=0x3001 -> no data_req; wb_valid=1, excp_ale=1, excp_badv=0x3001 next cycle.
REQ-036 LD.W accepted, addr_ok after 3 cycles, flush in WAIT, data_ok 2 cycles later -> DISCARD then IDLE, wb_valid never 1, stallreq high throughout.
REQ-037 rst asserted mid-cycle during REQ -> data_req=0 and stallreq=0 immediately, without waiting for a clock edge.
